// File: rtl/gs_ddram_bridge.sv
// gs_ddram_bridge: byte-wide General Sound memory port onto the 64-bit DDR3 Avalon port.
// Reads go through a single 8-byte line buffer. Writes always go to DDR3, and they also
// patch the buffered line when the write hits it.
`timescale 1ns/1ps

module gs_ddram_bridge #(
  parameter logic [28:0] BASE = 29'h0600_0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        we,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  typedef enum logic [1:0] {IDLE, RDREQ, RDWAIT, WR} state_t;

  state_t      state;
  logic        old_rd;
  logic        old_we;
  logic [20:0] addr_q;
  logic [7:0]  din_q;
  logic [63:0] line;
  logic [17:0] tag;
  logic        valid;
  logic        rd_req;
  logic        wr_req;
  logic        hit;

  assign rd_req = rd & ~old_rd;
  assign wr_req = we & ~old_we;
  assign hit    = valid && (tag == addr[20:3]);

  // The high address bits come from BASE with no carry, so a wrap at the top of the 2 MB space stays inside the window.
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = {BASE[28:18], addr_q[20:3]};
  assign DDRAM_DIN      = {8{din_q}};
  assign DDRAM_BE       = DDRAM_WE ? (8'd1 << addr_q[2:0]) : 8'hFF;

  // Register the request levels so that only a rising edge of rd or we counts as a new access.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_rd <= 1'b0;
      old_we <= 1'b0;
    end else begin
      old_rd <= rd;
      old_we <= we;
    end
  end

  // Access sequencer and line buffer. Only one access is outstanding at a time, and request edges seen outside IDLE are dropped.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      dout     <= 8'h00;
      valid    <= 1'b0;
      tag      <= 18'h0;
      line     <= 64'h0;
      addr_q   <= 21'h0;
      din_q    <= 8'h00;
      DDRAM_RD <= 1'b0;
      DDRAM_WE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            addr_q   <= addr;
            din_q    <= din;
            ready    <= 1'b0;
            DDRAM_WE <= 1'b1;
            if (hit) begin
              line[{addr[2:0], 3'b000} +: 8] <= din;
            end
            state <= WR;
          end else if (rd_req) begin
            if (hit) begin
              dout <= line[{addr[2:0], 3'b000} +: 8];
            end else begin
              addr_q   <= addr;
              ready    <= 1'b0;
              DDRAM_RD <= 1'b1;
              state    <= RDREQ;
            end
          end
        end
        RDREQ: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state    <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (DDRAM_DOUT_READY) begin
            line  <= DDRAM_DOUT;
            tag   <= addr_q[20:3];
            valid <= 1'b1;
            dout  <= DDRAM_DOUT[{addr_q[2:0], 3'b000} +: 8];
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        WR: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// tb_gs_ddram_bridge: drives GS byte accesses against a simple DDR3 responder. The expected
// data, hit/miss decisions and cycle counts come from a transaction-level model of the line buffer.
`timescale 1ns/1ps

module tb_gs_ddram_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [20:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        we;
  logic        ready;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  int total = 0;
  int bad = 0;

  // Transaction-level reference: byte memory as seen by the GS, plus which qword is buffered.
  logic [7:0]  refMem [int];
  bit          refValid;
  logic [17:0] refTag;

  // DDR3 responder state.
  logic [63:0] ddrMem [int];
  logic [63:0] preMem [int];
  int          busyPlan = 0;
  int          busySeen = 0;
  int          latency = 1;
  int          countdown = 0;
  int          rdCmdCount = 0;
  int          wrCmdCount = 0;
  logic [28:0] lastRdAddr = '0;
  logic [7:0]  lastWrBe = '0;
  logic [63:0] lastWrDin = '0;
  logic [28:0] pendAddr = '0;
  bit          accRd;
  bit          accWr;
  logic [28:0] capAddr;
  logic [7:0]  capBe;
  logic [63:0] capDin;
  logic [63:0] word;

  // Expectations shared with the per-cycle monitor.
  logic [20:0] curAddr = '0;
  logic [7:0]  curDin = '0;
  bit          monitorOn = 1'b0;
  int          lastReadyLow;
  int          lastRdHigh;
  int          lastWeHigh;
  logic [7:0]  lastDout;

  gs_ddram_bridge dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .addr(addr),
    .din(din),
    .dout(dout),
    .rd(rd),
    .we(we),
    .ready(ready),
    .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD),
    .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE),
    .DDRAM_WE(DDRAM_WE)
  );

  // Free-running system clock.
  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] initByte(input logic [20:0] x);
    return (x[7:0] * 8'd29) ^ x[15:8] ^ {3'b000, x[20:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] refByte(input logic [20:0] a);
    if (refMem.exists(int'(a))) return refMem[int'(a)];
    return initByte(a);
  endfunction

  function automatic logic [63:0] readQword(input logic [28:0] q);
    logic [63:0] w;
    if (ddrMem.exists(int'(q))) return ddrMem[int'(q)];
    if (preMem.exists(int'(q))) return preMem[int'(q)];
    for (int i = 0; i < 8; i++) w[8*i +: 8] = initByte({q[17:0], 3'(i)});
    return w;
  endfunction

  function automatic logic [28:0] expQaddr(input logic [20:0] a);
    return 29'h0600_0000 + 29'(a / 8);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [17:0] q, input logic [63:0] v);
    preMem[int'(29'h0600_0000 + 29'(q))] = v;
    for (int i = 0; i < 8; i++) refMem[int'({q, 3'(i)})] = v[8*i +: 8];
  endtask

  // DDR3 responder: applies busy stretching, accepts commands, commits writes, and returns read data a fixed latency later.
  always begin
    @(negedge clk_sys);
    accRd = DDRAM_RD && !DDRAM_BUSY && !reset;
    accWr = DDRAM_WE && !DDRAM_BUSY && !reset;
    if ((DDRAM_RD || DDRAM_WE) && DDRAM_BUSY) busySeen++;
    capAddr = DDRAM_ADDR;
    capBe = DDRAM_BE;
    capDin = DDRAM_DIN;
    @(posedge clk_sys);
    #1;
    DDRAM_DOUT_READY = 1'b0;
    if (accWr) begin
      word = readQword(capAddr);
      for (int i = 0; i < 8; i++) if (capBe[i]) word[8*i +: 8] = capDin[8*i +: 8];
      ddrMem[int'(capAddr)] = word;
      wrCmdCount++;
      lastWrBe = capBe;
      lastWrDin = capDin;
      busySeen = 0;
    end
    if (accRd) begin
      rdCmdCount++;
      lastRdAddr = capAddr;
      pendAddr = capAddr;
      countdown = latency;
      busySeen = 0;
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = readQword(pendAddr);
      end
    end
    DDRAM_BUSY = (busySeen < busyPlan);
  end

  // Per-cycle monitor: command fields must match the access in flight, and read and write commands must never overlap.
  always @(negedge clk_sys) begin
    if (!reset && monitorOn) begin
      checkOutput("burstcnt", 64'(DDRAM_BURSTCNT), 64'(8'd1));
      checkOutput("cmdExclusive", 64'(DDRAM_RD & DDRAM_WE), 64'(0));
      if (DDRAM_RD) begin
        checkOutput("rdAddr", 64'(DDRAM_ADDR), 64'(expQaddr(curAddr)));
        checkOutput("rdBe", 64'(DDRAM_BE), 64'(8'hFF));
      end
      if (DDRAM_WE) begin
        checkOutput("wrAddr", 64'(DDRAM_ADDR), 64'(expQaddr(curAddr)));
        checkOutput("wrBe", 64'(DDRAM_BE), 64'(2 ** curAddr[2:0]));
        checkOutput("wrDin", DDRAM_DIN, {8{curDin}});
      end
    end
  end

  // One GS access from request edge to completion, scored against the reference model.
  task automatic applyStimulus(input bit doWr, input bit doRd, input logic [20:0] a,
                               input logic [7:0] d, input int b, input int lat);
    bit hit;
    int rdBefore;
    int wrBefore;
    int readyLow;
    int rdHigh;
    int weHigh;
    logic [7:0] expByte;
    hit = !doWr && refValid && (refTag == a[20:3]);
    expByte = refByte(a);
    rdBefore = rdCmdCount;
    wrBefore = wrCmdCount;
    curAddr = a;
    curDin = d;
    busyPlan = b;
    latency = lat;
    addr = a;
    din = d;
    rd = doRd;
    we = doWr;
    readyLow = 0;
    rdHigh = 0;
    weHigh = 0;
    @(posedge clk_sys);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_sys);
      if (!ready) readyLow++;
      if (DDRAM_RD) rdHigh++;
      if (DDRAM_WE) weHigh++;
      if (ready) break;
      @(posedge clk_sys);
      #1;
      rd = 1'b0;
      we = 1'b0;
    end
    lastReadyLow = readyLow;
    lastRdHigh = rdHigh;
    lastWeHigh = weHigh;
    lastDout = dout;
    checkOutput("readyReturn", 64'(ready), 64'(1));
    if (doWr) begin
      checkOutput("wrReadyLow", 64'(readyLow), 64'(b + 1));
      checkOutput("wrWeHigh", 64'(weHigh), 64'(b + 1));
      checkOutput("wrNoRdCmd", 64'(rdHigh), 64'(0));
      checkOutput("wrCmdCount", 64'(wrCmdCount - wrBefore), 64'(1));
      checkOutput("wrNoDdrRead", 64'(rdCmdCount - rdBefore), 64'(0));
      refMem[int'(a)] = d;
    end else if (hit) begin
      checkOutput("hitReadyLow", 64'(readyLow), 64'(0));
      checkOutput("hitNoRdCmd", 64'(rdCmdCount - rdBefore), 64'(0));
      checkOutput("hitDout", 64'(dout), 64'(expByte));
    end else begin
      checkOutput("missReadyLow", 64'(readyLow), 64'(b + lat + 2));
      checkOutput("missRdHigh", 64'(rdHigh), 64'(b + 1));
      checkOutput("missNoWe", 64'(weHigh), 64'(0));
      checkOutput("missRdCount", 64'(rdCmdCount - rdBefore), 64'(1));
      checkOutput("missDout", 64'(dout), 64'(expByte));
      refValid = 1'b1;
      refTag = a[20:3];
    end
    @(posedge clk_sys);
    #1;
    rd = 1'b0;
    we = 1'b0;
    @(posedge clk_sys);
    #1;
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    int rdBefore;
    logic [17:0] q;
    logic [20:0] a;
    int kind;
    reset = 1'b1;
    addr = '0;
    din = '0;
    rd = 1'b0;
    we = 1'b0;
    DDRAM_BUSY = 1'b0;
    DDRAM_DOUT = '0;
    DDRAM_DOUT_READY = 1'b0;
    refValid = 1'b0;
    refTag = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(negedge clk_sys);
    checkOutput("resetReady", 64'(ready), 64'(1));
    checkOutput("resetDout", 64'(dout), 64'(0));
    checkOutput("resetRd", 64'(DDRAM_RD), 64'(0));
    checkOutput("resetWe", 64'(DDRAM_WE), 64'(0));
    @(posedge clk_sys);
    #1;
    monitorOn = 1'b1;

    $display("[TB] cold read");
    preload(18'h0, 64'h8877665544332211);
    applyStimulus(1'b0, 1'b1, 21'h000005, 8'h00, 0, 10);
    checkOutput("coldDout", 64'(lastDout), 64'(8'h66));
    checkOutput("coldReadyLow", 64'(lastReadyLow), 64'(12));
    checkOutput("coldRdAddr", 64'(lastRdAddr), 64'(29'h0600_0000));
    checkOutput("coldRdHigh", 64'(lastRdHigh), 64'(1));

    $display("[TB] hit read");
    applyStimulus(1'b0, 1'b1, 21'h000007, 8'h00, 0, 10);
    checkOutput("hitDoutLit", 64'(lastDout), 64'(8'h88));
    checkOutput("hitReadyLowLit", 64'(lastReadyLow), 64'(0));

    $display("[TB] write-through on hit");
    applyStimulus(1'b1, 1'b0, 21'h000002, 8'hAB, 0, 1);
    checkOutput("wtBe", 64'(lastWrBe), 64'(8'h04));
    checkOutput("wtDin", lastWrDin, 64'hABABABABABABABAB);
    applyStimulus(1'b0, 1'b1, 21'h000002, 8'h00, 0, 10);
    checkOutput("wtReadBack", 64'(lastDout), 64'(8'hAB));

    $display("[TB] busy stretch and simultaneous edges");
    applyStimulus(1'b1, 1'b0, 21'h000003, 8'h5A, 3, 1);
    checkOutput("busyWeHigh", 64'(lastWeHigh), 64'(4));
    checkOutput("busyReadyLow", 64'(lastReadyLow), 64'(4));
    applyStimulus(1'b1, 1'b1, 21'h000004, 8'hC3, 0, 1);
    checkOutput("bothNoRd", 64'(lastRdHigh), 64'(0));

    $display("[TB] wrap and tag");
    applyStimulus(1'b0, 1'b1, 21'h1FFFF8, 8'h00, 0, 4);
    checkOutput("wrapAddr", 64'(lastRdAddr), 64'(29'h0603_FFFF));
    applyStimulus(1'b0, 1'b1, 21'h000000, 8'h00, 0, 4);
    checkOutput("retagDout", 64'(lastDout), 64'(8'h11));

    $display("[TB] reset during read wait");
    rdBefore = rdCmdCount;
    curAddr = 21'h000123;
    busyPlan = 0;
    latency = 6;
    addr = 21'h000123;
    rd = 1'b1;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    rd = 1'b0;
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    refValid = 1'b0;
    @(negedge clk_sys);
    checkOutput("rstMidReady", 64'(ready), 64'(1));
    checkOutput("rstMidRd", 64'(DDRAM_RD), 64'(0));
    checkOutput("rstMidDout", 64'(dout), 64'(0));
    checkOutput("rstMidIssued", 64'(rdCmdCount - rdBefore), 64'(1));
    repeat (8) @(posedge clk_sys);
    #1;
    @(negedge clk_sys);
    checkOutput("lateDataReady", 64'(ready), 64'(1));
    checkOutput("lateDataDout", 64'(dout), 64'(0));
    @(posedge clk_sys);
    #1;
    applyStimulus(1'b0, 1'b1, 21'h000123, 8'h00, 0, 3);
    checkOutput("rstRereadHigh", 64'(lastRdHigh), 64'(1));

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0: q = 18'h00000;
        1: q = 18'h3FFFF;
        2: q = 18'h00001;
        3: q = 18'h12345;
        default: q = 18'($urandom);
      endcase
      a = {q, 3'($urandom)};
      kind = int'($urandom_range(0, 9));
      applyStimulus(kind < 3, (kind != 1) && (kind != 2), a, 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
    end

    monitorOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
